// File: rtl/stm_transition_scheduler.sv
// stm_transition_scheduler: holds one pending STM switch request and pulses UPDATE_SETTINGS when its trigger fires
module stm_transition_scheduler #(
  parameter int SYS_TIME_W = 56,
  parameter int GPIO_N = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  input  logic                  REQ_MODE,
  input  logic                  REQ_SEGMENT,
  input  logic [31:0]           REQ_REP,
  input  logic [2:0]            TRANS_MODE,
  input  logic [63:0]           TRANS_VALUE,
  input  logic [SYS_TIME_W-1:0] SYS_TIME,
  input  logic [GPIO_N-1:0]     GPIO_IN,
  input  logic                  STOP_IN,
  output logic                  UPDATE_SETTINGS,
  output logic                  MODE_OUT,
  output logic                  SEGMENT_OUT,
  output logic [31:0]           REP_OUT,
  output logic                  BUSY,
  output logic                  LATE,
  output logic                  DROPPED,
  output logic                  INVALID
);
  localparam int GW = GPIO_N > 1 ? $clog2(GPIO_N) : 1;
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state;
  logic [1:0] tmode;
  logic [SYS_TIME_W-1:0] target;
  logic [GW-1:0] gidx;
  logic first;
  logic [GPIO_N-1:0] gpio_prev;
  logic req_ok, cond;
  always_comb begin
    req_ok = TRANS_MODE < 3'd4 && (TRANS_MODE != 3'd2 || TRANS_VALUE < 64'(GPIO_N));
    cond = tmode == 2'd0 ? 1'b1 :
           tmode == 2'd1 ? SYS_TIME >= target :
           tmode == 2'd2 ? GPIO_IN[gidx] & ~gpio_prev[gidx] : STOP_IN;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      tmode <= '0;
      target <= '0;
      gidx <= '0;
      first <= 1'b0;
      gpio_prev <= '0;
      UPDATE_SETTINGS <= 1'b0;
      BUSY <= 1'b0;
      LATE <= 1'b0;
      DROPPED <= 1'b0;
      INVALID <= 1'b0;
      MODE_OUT <= 1'b0;
      SEGMENT_OUT <= 1'b0;
      REP_OUT <= '1;
    end else begin
      gpio_prev <= GPIO_IN;
      UPDATE_SETTINGS <= 1'b0;
      LATE <= 1'b0;
      DROPPED <= 1'b0;
      INVALID <= REQ_VALID && !req_ok;
      first <= 1'b0;
      if (REQ_VALID && req_ok) begin
        state <= ARMED;
        BUSY <= 1'b1;
        first <= 1'b1;
        DROPPED <= state == ARMED;
        tmode <= TRANS_MODE[1:0];
        target <= TRANS_VALUE[SYS_TIME_W-1:0];
        gidx <= TRANS_VALUE[GW-1:0];
        MODE_OUT <= REQ_MODE;
        SEGMENT_OUT <= REQ_SEGMENT;
        REP_OUT <= REQ_REP;
      end else if (state == ARMED && cond) begin
        state <= IDLE;
        BUSY <= 1'b0;
        UPDATE_SETTINGS <= 1'b1;
        LATE <= first && tmode == 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_stm_transition_scheduler.sv
// tb_stm_transition_scheduler: directed bench with a request-level reference model and literal spot checks
module tb_stm_transition_scheduler;
  localparam int STW = 56;
  localparam int GN = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic REQ_VALID = 1'b0;
  logic REQ_MODE = 1'b0;
  logic REQ_SEGMENT = 1'b0;
  logic [31:0] REQ_REP = '0;
  logic [2:0] TRANS_MODE = '0;
  logic [63:0] TRANS_VALUE = '0;
  logic [STW-1:0] SYS_TIME = '0;
  logic [GN-1:0] GPIO_IN = '0;
  logic STOP_IN = 1'b0;
  logic UPDATE_SETTINGS, MODE_OUT, SEGMENT_OUT, BUSY, LATE, DROPPED, INVALID;
  logic [31:0] REP_OUT;
  int checks = 0;
  int errors = 0;
  bit count_en = 1'b0;

  stm_transition_scheduler #(.SYS_TIME_W(STW), .GPIO_N(GN)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_MODE(REQ_MODE),
    .REQ_SEGMENT(REQ_SEGMENT), .REQ_REP(REQ_REP), .TRANS_MODE(TRANS_MODE),
    .TRANS_VALUE(TRANS_VALUE), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .STOP_IN(STOP_IN),
    .UPDATE_SETTINGS(UPDATE_SETTINGS), .MODE_OUT(MODE_OUT), .SEGMENT_OUT(SEGMENT_OUT),
    .REP_OUT(REP_OUT), .BUSY(BUSY), .LATE(LATE), .DROPPED(DROPPED), .INVALID(INVALID)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit on;
    int tm;
    logic [STW-1:0] tgt;
    int idx;
    int arm;
  } pend_t;

  initial begin
    pend_t p;
    bit m_on, ok, hit;
    int cyc;
    logic [GN-1:0] g_last;
    logic e_upd, e_busy, e_late, e_drop, e_inv, e_mode, e_seg;
    logic [31:0] e_rep;
    m_on = 0;
    cyc = 0;
    p.on = 0;
    g_last = '0;
    forever begin
      @(posedge CLK);
      cyc++;
      if (RST) begin
        m_on = 1;
        p.on = 0;
        g_last = '0;
        {e_upd, e_busy, e_late, e_drop, e_inv, e_mode, e_seg} = '0;
        e_rep = 32'hFFFFFFFF;
      end else begin
        {e_upd, e_late, e_drop} = '0;
        ok = TRANS_MODE < 4 && (TRANS_MODE != 2 || TRANS_VALUE < 64'(GN));
        case (p.tm)
          0: hit = 1;
          1: hit = SYS_TIME >= p.tgt;
          2: hit = GPIO_IN[p.idx] && !g_last[p.idx];
          default: hit = STOP_IN;
        endcase
        hit = hit && p.on;
        e_inv = REQ_VALID && !ok;
        if (REQ_VALID && ok) begin
          e_drop = p.on;
          p.on = 1;
          p.tm = int'(TRANS_MODE);
          p.tgt = TRANS_VALUE[STW-1:0];
          p.idx = int'(TRANS_VALUE[1:0]);
          p.arm = cyc + 1;
          e_mode = REQ_MODE;
          e_seg = REQ_SEGMENT;
          e_rep = REQ_REP;
        end else if (hit) begin
          e_upd = 1;
          e_late = p.tm == 1 && cyc == p.arm;
          p.on = 0;
        end
        e_busy = p.on;
        g_last = GPIO_IN;
      end
      @(negedge CLK);
      if (m_on)
        check($sformatf("model_cyc%0d", cyc),
              {25'd0, UPDATE_SETTINGS, BUSY, LATE, DROPPED, INVALID, MODE_OUT, SEGMENT_OUT, REP_OUT},
              {25'd0, e_upd, e_busy, e_late, e_drop, e_inv, e_mode, e_seg, e_rep});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (count_en) SYS_TIME++;
  endtask

  task automatic req(input bit m, input bit s, input logic [31:0] r, input logic [2:0] tm, input logic [63:0] tv);
    REQ_VALID = 1;
    REQ_MODE = m;
    REQ_SEGMENT = s;
    REQ_REP = r;
    TRANS_MODE = tm;
    TRANS_VALUE = tv;
    tick();
    REQ_VALID = 0;
  endtask

  initial begin
    int k;
    repeat (3) tick();
    RST = 0;
    check("rst_update", UPDATE_SETTINGS, 0);
    check("rst_busy", BUSY, 0);
    check("rst_rep", REP_OUT, 32'hFFFFFFFF);
    check("rst_mode_seg", {MODE_OUT, SEGMENT_OUT}, 0);
    repeat (6) tick();
    // immediate request: BUSY for one cycle, pulse two cycles after the strobe
    req(0, 1, 32'hFFFFFFFF, 0, 0);
    check("t1_busy", BUSY, 1);
    check("t1_no_early", UPDATE_SETTINGS, 0);
    tick();
    check("t1_update", UPDATE_SETTINGS, 1);
    check("t1_seg", SEGMENT_OUT, 1);
    check("t1_busy_off", BUSY, 0);
    tick();
    check("t1_single", UPDATE_SETTINGS, 0);
    // system time target reached while armed
    SYS_TIME = 990;
    count_en = 1;
    req(1, 0, 7, 1, 1000);
    k = 0;
    while (!UPDATE_SETTINGS && k < 30) begin
      tick();
      k++;
    end
    check("t2_wait", k, 10);
    check("t2_late0", LATE, 0);
    check("t2_systime", SYS_TIME, 1001);
    count_en = 0;
    SYS_TIME = 990;
    tick();
    // system time target already past
    req(0, 1, 3, 1, 500);
    check("t2b_no_early", UPDATE_SETTINGS, 0);
    tick();
    check("t2b_update", UPDATE_SETTINGS, 1);
    check("t2b_late", LATE, 1);
    // GPIO held high before arming must not fire
    GPIO_IN = 4'b0100;
    tick();
    req(1, 1, 11, 2, 2);
    repeat (3) tick();
    check("t3_held", {BUSY, UPDATE_SETTINGS}, 2'b10);
    GPIO_IN = 4'b0000;
    tick();
    check("t3_fall", UPDATE_SETTINGS, 0);
    GPIO_IN = 4'b0100;
    tick();
    check("t3_rise", UPDATE_SETTINGS, 1);
    GPIO_IN = 4'b0000;
    // STOP trigger with finite repeat count
    req(0, 0, 5, 3, 0);
    repeat (20) tick();
    check("t4_wait", {BUSY, UPDATE_SETTINGS}, 2'b10);
    STOP_IN = 1;
    tick();
    STOP_IN = 0;
    check("t4_update", UPDATE_SETTINGS, 1);
    check("t4_rep", REP_OUT, 5);
    // replacement of a pending request
    req(1, 1, 21, 1, 5000);
    repeat (2) tick();
    req(0, 0, 22, 0, 0);
    check("t5_dropped", DROPPED, 1);
    check("t5_no_update", UPDATE_SETTINGS, 0);
    tick();
    check("t5_update", UPDATE_SETTINGS, 1);
    check("t5_fields", {MODE_OUT, SEGMENT_OUT, REP_OUT}, {2'b00, 32'd22});
    // back-to-back immediate requests, each issued on the previous pulse cycle
    for (int i = 0; i < 4; i++) begin
      req(i[0], ~i[0], 32'(100 + i), 0, 0);
      check($sformatf("b2b_nodrop%0d", i), DROPPED, 0);
      tick();
      check($sformatf("b2b_pulse%0d", i), {UPDATE_SETTINGS, REP_OUT}, {1'b1, 32'(100 + i)});
    end
    tick();
    // invalid requests leave outputs untouched
    req(1, 1, 77, 6, 0);
    check("t6_invalid", INVALID, 1);
    check("t6_unchanged", {BUSY, MODE_OUT, SEGMENT_OUT, REP_OUT}, {3'b010, 32'd103});
    tick();
    check("t6_no_update", {INVALID, UPDATE_SETTINGS}, 0);
    req(0, 0, 78, 2, 7);
    check("t6_gpio_idx", {INVALID, BUSY}, 2'b10);
    // invalid strobe while armed keeps the pending request
    req(0, 1, 9, 3, 0);
    req(1, 0, 8, 7, 0);
    check("t6_keep", {INVALID, BUSY, REP_OUT}, {2'b11, 32'd9});
    STOP_IN = 1;
    tick();
    STOP_IN = 0;
    check("t6_kept_fire", UPDATE_SETTINGS, 1);
    // reset while armed aborts silently
    req(1, 1, 9, 3, 0);
    RST = 1;
    tick();
    RST = 0;
    check("t6_rst", {BUSY, MODE_OUT, SEGMENT_OUT, REP_OUT}, {3'b000, 32'hFFFFFFFF});
    STOP_IN = 1;
    repeat (3) tick();
    check("t6_rst_noupd", UPDATE_SETTINGS, 0);
    STOP_IN = 0;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
